// File: rtl/overlay_pixel_mixer_if.sv
// ============================================================================
// Module  : overlay_pixel_mixer_if
// Brief   : Overlay pixel stream from the DDR reader into the mixer FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface overlay_pixel_mixer_if;
    logic [23:0] pixelIn;
    logic        pixelSof;
    logic        pixelValid;
    logic        pixelReady;

    modport master (output pixelIn, pixelSof, pixelValid, input pixelReady);
    modport slave  (input pixelIn, pixelSof, pixelValid, output pixelReady);
endinterface

`default_nettype wire

// File: rtl/overlay_pixel_mixer.sv
// ============================================================================
// Module  : overlay_pixel_mixer
// Brief   : FIFO-buffered overlay window mixer onto the HDMI pixel bus, 2-clock
//           latency. Optional macro CHROMA_KEY_EN makes KEY_COLOUR transparent.
// Revision: 1.0
// ============================================================================
`default_nettype none

module overlay_pixel_mixer #(
    parameter int          hBusWidth        = 12,
    parameter int          vBusWidth        = 12,
    parameter int          ovlWidth         = 640,
    parameter int          ovlHeight        = 480,
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [23:0] BG_COLOUR        = 24'h000000,
    parameter logic [23:0] UNDERFLOW_COLOUR = 24'hFF00FF,
    parameter logic [23:0] KEY_COLOUR       = 24'h00FF00
) (
    input  logic                 clock,
    input  logic                 masterReset_n,
    input  logic [hBusWidth-1:0] hCount,
    input  logic [vBusWidth-1:0] vCount,
    input  logic                 deIn,
    input  logic                 frameStart,
    input  logic [hBusWidth-1:0] xStart,
    input  logic [vBusWidth-1:0] yStart,
    overlay_pixel_mixer_if.slave pix,
    input  logic                 clearUnderflow,
    output logic [23:0]          dataOut,
    output logic                 deOut,
    output logic                 underflow
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = AW + 1;
    localparam int NPIX = ovlWidth * ovlHeight;
    localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0]  c_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [PCW-1:0] c_LAST  = PCW'(NPIX - 1);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [24:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wrPtr;
    logic [AW-1:0]        r_rdPtr;
    logic [CW-1:0]        r_count;
    logic                 r_rstDone;
    logic [hBusWidth-1:0] r_xS;
    logic [vBusWidth-1:0] r_yS;
    logic [PCW-1:0]       r_pixCnt;
    logic [23:0]          r_s1Data;
    logic                 r_s1De;
    logic [23:0]          r_dataOut;
    logic                 r_deOut;
    logic                 r_underflow;

    logic                 w_empty;
    logic                 w_ready;
    logic [24:0]          w_head;
    logic [hBusWidth:0]   w_xEnd;
    logic [vBusWidth:0]   w_yEnd;
    logic                 w_inWin;
    logic                 w_popReq;
    logic                 w_underEvt;
    logic                 w_winPop;
    logic                 w_badSof;
    logic                 w_consume;
    logic                 w_keyHit;
    logic                 w_discard;
    logic                 w_latch;
    logic                 w_push;
    logic                 w_pop;
    logic [23:0]          w_s1Next;

    assign w_empty        = (r_count == '0);
    assign w_ready        = r_rstDone && (r_count < c_DEPTH);
    assign w_head         = r_mem[r_rdPtr];
    assign pix.pixelReady = w_ready;

    // One extra bit on the window end so a window touching the counter limit cannot wrap.
    assign w_xEnd  = {1'b0, r_xS} + (hBusWidth+1)'(ovlWidth - 1);
    assign w_yEnd  = {1'b0, r_yS} + (vBusWidth+1)'(ovlHeight - 1);
    assign w_inWin = deIn && !frameStart
                  && ({1'b0, hCount} >= {1'b0, r_xS}) && ({1'b0, hCount} <= w_xEnd)
                  && ({1'b0, vCount} >= {1'b0, r_yS}) && ({1'b0, vCount} <= w_yEnd);

    assign w_popReq   = w_inWin && (r_state == ACTIVE);
    assign w_underEvt = w_popReq && w_empty;
    assign w_winPop   = w_popReq && !w_empty;
    // A start-of-image beat mid-image is left in the FIFO so the next image stays intact.
    assign w_badSof   = w_winPop && w_head[24] && (r_pixCnt != '0);
    assign w_consume  = w_winPop && !w_badSof;
    assign w_pop      = w_consume || w_discard;

`ifdef CHROMA_KEY_EN
    assign w_keyHit = (w_head[23:0] == KEY_COLOUR);
`else
    assign w_keyHit = (w_head[23:0] == KEY_COLOUR) & 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        w_discard   = 1'b0;
        w_latch     = 1'b0;
        w_push      = pix.pixelValid && w_ready;
        case (r_state)
            WAIT_SOF: begin
                w_discard = !w_empty && !w_head[24];
                if (frameStart) begin
                    w_latch     = 1'b1;
                    w_nextState = ACTIVE;
                end
            end
            ACTIVE: begin
                if (frameStart || w_badSof) begin
                    w_nextState = FLUSH;
                end else if (w_winPop && (r_pixCnt == c_LAST)) begin
                    w_nextState = WAIT_SOF;
                end
            end
            FLUSH: begin
                if (!w_empty && w_head[24]) begin
                    w_nextState = WAIT_SOF;
                end else begin
                    w_discard = !w_empty;
                    if (w_push && pix.pixelSof) begin
                        w_nextState = WAIT_SOF;
                    end else begin
                        w_push = 1'b0;
                    end
                end
            end
            default: w_nextState = WAIT_SOF;
        endcase
    end

    always_comb begin
        w_s1Next = BG_COLOUR;
        if (w_consume) begin
            w_s1Next = w_keyHit ? BG_COLOUR : w_head[23:0];
        end else if (w_underEvt || w_badSof) begin
            w_s1Next = UNDERFLOW_COLOUR;
        end
    end

    always_ff @(posedge clock or negedge masterReset_n) begin
        if (!masterReset_n) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {pix.pixelSof, pix.pixelIn};
        end
    end

    always_ff @(posedge clock or negedge masterReset_n) begin
        if (!masterReset_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_rstDone   <= 1'b0;
            r_xS        <= '0;
            r_yS        <= '0;
            r_pixCnt    <= '0;
            r_s1Data    <= BG_COLOUR;
            r_s1De      <= 1'b0;
            r_dataOut   <= BG_COLOUR;
            r_deOut     <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rstDone <= 1'b1;
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_latch) begin
                r_xS     <= xStart;
                r_yS     <= yStart;
                r_pixCnt <= '0;
            end else if (w_consume) begin
                r_pixCnt <= (r_pixCnt == c_LAST) ? '0 : r_pixCnt + 1'b1;
            end
            r_s1Data  <= w_s1Next;
            r_s1De    <= deIn;
            r_dataOut <= r_s1Data;
            r_deOut   <= r_s1De;
            if (w_underEvt || w_badSof) begin
                r_underflow <= 1'b1;
            end else if (clearUnderflow) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign dataOut   = r_dataOut;
    assign deOut     = r_deOut;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_overlay_pixel_mixer.sv
// ============================================================================
// Module  : tb_overlay_pixel_mixer
// Brief   : Randomised and directed bench for overlay_pixel_mixer with a
//           queue-based reference model; honours CHROMA_KEY_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_overlay_pixel_mixer;
    localparam int HBW = 12, VBW = 12, OW = 4, OH = 2, DEPTH = 16;
    localparam logic [23:0] BG = 24'h000000, UFC = 24'hFF00FF, KEY = 24'h00FF00;
    localparam int H_TOT = 20, V_TOT = 10, H_ACT = 16, V_ACT = 8;
    localparam int M_WAIT = 0, M_ACTIVE = 1, M_FLUSH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [HBW-1:0] hCount = '0;
    logic [VBW-1:0] vCount = '0;
    logic [HBW-1:0] xStart = '0;
    logic [VBW-1:0] yStart = '0;
    logic deIn = 1'b0, frameStart = 1'b0, clearUnderflow = 1'b0;
    logic [23:0] dataOut;
    logic deOut, underflow;

    overlay_pixel_mixer_if pif();

    overlay_pixel_mixer #(
        .hBusWidth(HBW), .vBusWidth(VBW), .ovlWidth(OW), .ovlHeight(OH),
        .FIFO_DEPTH(DEPTH), .BG_COLOUR(BG), .UNDERFLOW_COLOUR(UFC), .KEY_COLOUR(KEY)
    ) dut (
        .clock(clk), .masterReset_n(rst_n), .hCount(hCount), .vCount(vCount),
        .deIn(deIn), .frameStart(frameStart), .xStart(xStart), .yStart(yStart),
        .pix(pif), .clearUnderflow(clearUnderflow),
        .dataOut(dataOut), .deOut(deOut), .underflow(underflow)
    );

    int n_cmp = 0, n_bad = 0, n_acc = 0;

    // reference model state (what the outputs must be after the latest edge)
    logic [24:0] mq[$];
    int m_mode, m_xs, m_ys, m_popped;
    bit m_started, m_uf, m_de1, m_de2;
    logic [23:0] m_d1, m_d2;

    // stimulus state
    logic [24:0] src[$];
    logic [23:0] cap[$];
    bit raster_on = 0, gate_rand = 0, clr_rand = 0, clr_force = 0, cap_en = 0;
    bit man_fs = 0, man_de = 0;
    int man_h = 0, man_v = 0, rh = 0, rv = 0;
    int hd1 = 0, vd1 = 0, hd2 = 0, vd2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = M_WAIT; m_xs = 0; m_ys = 0; m_popped = 0;
        m_started = 0; m_uf = 0;
        m_d1 = BG; m_d2 = BG; m_de1 = 0; m_de2 = 0;
    endtask

    task automatic model_step(output bit acc);
        bit ready, inwin, popreq, pop, push, set_uf;
        logic [23:0] px;
        int nmode;
        ready  = m_started && (mq.size() < DEPTH);
        inwin  = deIn && !frameStart
              && int'(hCount) >= m_xs && int'(hCount) <= m_xs + OW - 1
              && int'(vCount) >= m_ys && int'(vCount) <= m_ys + OH - 1;
        popreq = inwin && (m_mode == M_ACTIVE);
        px = BG; set_uf = 0; pop = 0; nmode = m_mode;
        push = pif.pixelValid && ready;
        acc  = push;
        if (popreq) begin
            if (mq.size() == 0) begin
                px = UFC; set_uf = 1;
            end else if (mq[0][24] && m_popped != 0) begin
                px = UFC; set_uf = 1; nmode = M_FLUSH;
            end else begin
                px = mq[0][23:0];
`ifdef CHROMA_KEY_EN
                if (px == KEY) px = BG;
`endif
                pop = 1;
                m_popped++;
                if (m_popped == OW * OH) nmode = M_WAIT;
            end
        end
        case (m_mode)
            M_WAIT: begin
                if (mq.size() != 0 && !mq[0][24]) pop = 1;
                if (frameStart) begin
                    m_xs = int'(xStart); m_ys = int'(yStart); m_popped = 0; nmode = M_ACTIVE;
                end
            end
            M_ACTIVE: if (frameStart) nmode = M_FLUSH;
            default: begin
                if (mq.size() != 0 && mq[0][24]) nmode = M_WAIT;
                else begin
                    if (mq.size() != 0) pop = 1;
                    if (push && pif.pixelSof) nmode = M_WAIT;
                    else push = 0;
                end
            end
        endcase
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({pif.pixelSof, pif.pixelIn});
        if (set_uf) m_uf = 1; else if (clearUnderflow) m_uf = 0;
        m_mode = nmode;
        m_d2 = m_d1; m_de2 = m_de1; m_d1 = px; m_de1 = deIn;
        m_started = 1;
    endtask

    always @(negedge clk) begin
        check("dataOut", 32'(dataOut), 32'(m_d2));
        check("deOut", 32'(deOut), 32'(m_de2));
        check("underflow", 32'(underflow), 32'(m_uf));
        check("pixelReady", 32'(pif.pixelReady), 32'(m_started && (mq.size() < DEPTH)));
        if (cap_en && m_de2 && hd2 >= 10 && hd2 <= 13 && vd2 >= 5 && vd2 <= 6)
            cap.push_back(dataOut);
    end

    task automatic cycle();
        bit acc;
        @(posedge clk); #1;
        acc = 0;
        if (rst_n) begin
            model_step(acc);
            if (acc) begin void'(src.pop_front()); n_acc++; end
        end
        hd2 = hd1; vd2 = vd1; hd1 = int'(hCount); vd1 = int'(vCount);
        if (raster_on) begin
            hCount = HBW'(rh); vCount = VBW'(rv);
            deIn = (rh < H_ACT) && (rv < V_ACT);
            frameStart = (rh == 0) && (rv == 0);
            rh++;
            if (rh == H_TOT) begin rh = 0; rv = (rv + 1) % V_TOT; end
        end else begin
            hCount = HBW'(man_h); vCount = VBW'(man_v); deIn = man_de; frameStart = man_fs;
        end
        clearUnderflow = clr_rand ? ($urandom_range(0, 15) == 0) : clr_force;
        if (src.size() != 0 && ((pif.pixelValid && !acc) || !gate_rand || $urandom_range(0, 3) != 0)) begin
            pif.pixelValid = 1'b1;
            {pif.pixelSof, pif.pixelIn} = src[0];
        end else begin
            pif.pixelValid = 1'b0;
        end
    endtask

    task automatic go_idle();
        raster_on = 0; rh = 0; rv = 0; man_fs = 0; man_de = 0; man_h = 0; man_v = 0;
        src.delete(); pif.pixelValid = 1'b0; pif.pixelSof = 1'b0; pif.pixelIn = '0;
        deIn = 0; frameStart = 0; hCount = '0; vCount = '0; clearUnderflow = 0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        go_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_frame();
        rh = 0; rv = 0; raster_on = 1;
        repeat (H_TOT * V_TOT) cycle();
        raster_on = 0;
        repeat (4) cycle();
    endtask

    task automatic load_image(input logic [23:0] base, input int len);
        for (int i = 0; i < len; i++) src.push_back({(i == 0), base + 24'(i)});
    endtask

    initial begin
        logic [23:0] exp6;
        int a0, len;
        go_idle();
        model_reset();
        xStart = 12'd10; yStart = 12'd5;
        do_reset();

        // reset mid-frame with 9 buffered beats
        load_image(24'h010000, 9);
        repeat (15) cycle();
        check("t1_fill9", mq.size(), 9);
        rh = 0; rv = 0; raster_on = 1;
        repeat (50) cycle();
        #2 rst_n = 1'b0;
        model_reset(); go_idle();
        #1;
        check("t1_data", 32'(dataOut), 32'h000000);
        check("t1_de", 32'(deOut), 0);
        check("t1_uf", 32'(underflow), 0);
        check("t1_ready", 32'(pif.pixelReady), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cycle();
        check("t1_ready_after", 32'(pif.pixelReady), 1);

        // prefilled 4x2 window at (10,5)
        do_reset();
        load_image(24'h100000, 8);
        repeat (20) cycle();
        cap.delete(); cap_en = 1; run_frame(); cap_en = 0;
        check("t2_count", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) check("t2_pix", 32'(cap[i]), 32'h100000 + i);
        check("t2_mode", m_mode, M_WAIT);

        // empty FIFO at the first window pixel
        do_reset();
        cap.delete(); cap_en = 1; run_frame(); cap_en = 0;
        if (cap.size() > 0) check("t3_first", 32'(cap[0]), 32'hFF00FF);
        else check("t3_first_seen", 0, 1);
        check("t3_uf_set", 32'(underflow), 1);
        clr_force = 1; cycle(); clr_force = 0; cycle();
        check("t3_uf_clr", 32'(underflow), 0);

        // full FIFO backpressure, one pop admits one beat
        do_reset();
        load_image(24'h200000, 20);
        repeat (30) cycle();
        check("t4_full_ready", 32'(pif.pixelReady), 0);
        check("t4_depth", mq.size(), DEPTH);
        man_fs = 1; cycle();
        man_fs = 0; man_h = 10; man_v = 5; man_de = 1; cycle();
        man_de = 0; cycle();
        a0 = n_acc;
        repeat (5) cycle();
        check("t4_one_beat", n_acc - a0, 1);
        check("t4_full_again", 32'(pif.pixelReady), 0);

        // short image, flush, resync
        do_reset();
        load_image(24'h300000, 3);
        repeat (10) cycle();
        run_frame();
        check("t5_mode_active", m_mode, M_ACTIVE);
        clr_force = 1; cycle(); clr_force = 0;
        src.push_back({1'b0, 24'h3A0000});
        src.push_back({1'b0, 24'h3A0001});
        load_image(24'h400000, 8);
        run_frame();
        check("t5_mode_wait", m_mode, M_WAIT);
        cap.delete(); cap_en = 1; run_frame(); cap_en = 0;
        check("t5_count", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) check("t5_pix", 32'(cap[i]), 32'h400000 + i);

        // chroma key pixel
        do_reset();
        load_image(24'h500000, 8);
        src[2] = {1'b0, KEY};
        repeat (20) cycle();
        cap.delete(); cap_en = 1; run_frame(); cap_en = 0;
`ifdef CHROMA_KEY_EN
        exp6 = BG;
`else
        exp6 = KEY;
`endif
        check("t6_count", cap.size(), 8);
        if (cap.size() > 3) begin
            check("t6_key", 32'(cap[2]), 32'(exp6));
            check("t6_next", 32'(cap[3]), 32'h500003);
        end

        // randomised frames
        do_reset();
        gate_rand = 1; clr_rand = 1;
        for (int f = 0; f < 14; f++) begin
            xStart = HBW'($urandom_range(0, 13));
            yStart = VBW'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: len = 5;
                1: len = 10;
                default: len = 8;
            endcase
            for (int i = 0; i < len; i++)
                src.push_back({(i == 0), ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom)});
            run_frame();
        end
        gate_rand = 0; clr_rand = 0;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
